// File: rtl/lcd_timing_engine_if.sv
// Config and pixel-request bus between the panel config logic / pixel source
// (master) and the LCD timing engine (slave).
interface lcd_timing_engine_if #(
    parameter int unsigned CW = 11,
    parameter int unsigned DW = 24
);
    logic          cfg_valid;
    logic          cfg_ready;
    logic [CW-1:0] cfg_h_sync;
    logic [CW-1:0] cfg_h_back;
    logic [CW-1:0] cfg_h_disp;
    logic [CW-1:0] cfg_h_front;
    logic [CW-1:0] cfg_v_sync;
    logic [CW-1:0] cfg_v_back;
    logic [CW-1:0] cfg_v_disp;
    logic [CW-1:0] cfg_v_front;
    logic          cfg_err;
    logic [CW-1:0] h_disp;
    logic [CW-1:0] v_disp;
    logic          pixel_req;
    logic [CW-1:0] pixel_x;
    logic [CW-1:0] pixel_y;
    logic [DW-1:0] pixel_data;
    logic          frame_start;
    logic          line_start;

    modport master (
        output cfg_valid, cfg_h_sync, cfg_h_back, cfg_h_disp, cfg_h_front,
               cfg_v_sync, cfg_v_back, cfg_v_disp, cfg_v_front, pixel_data,
        input  cfg_ready, cfg_err, h_disp, v_disp, pixel_req, pixel_x, pixel_y,
               frame_start, line_start
    );

    modport slave (
        input  cfg_valid, cfg_h_sync, cfg_h_back, cfg_h_disp, cfg_h_front,
               cfg_v_sync, cfg_v_back, cfg_v_disp, cfg_v_front, pixel_data,
        output cfg_ready, cfg_err, h_disp, v_disp, pixel_req, pixel_x, pixel_y,
               frame_start, line_start
    );
endinterface

// File: rtl/lcd_timing_engine.sv
// RGB LCD timing generator: DE/HS/VS, pixel requests and coordinates from a
// run-time loadable timing set that only takes effect on frame boundaries.
module lcd_timing_engine #(
    parameter int unsigned CW          = 11,
    parameter int unsigned DW          = 24,
    parameter int unsigned REQ_LEAD    = 1,   // legal 1..4
    parameter bit          DE_MODE     = 1'b1,
    parameter bit          HS_POL      = 1'b0,
    parameter bit          VS_POL      = 1'b0,
    parameter int unsigned RST_H_SYNC  = 41,
    parameter int unsigned RST_H_BACK  = 2,
    parameter int unsigned RST_H_DISP  = 480,
    parameter int unsigned RST_H_FRONT = 2,
    parameter int unsigned RST_V_SYNC  = 10,
    parameter int unsigned RST_V_BACK  = 2,
    parameter int unsigned RST_V_DISP  = 272,
    parameter int unsigned RST_V_FRONT = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    lcd_timing_engine_if.slave  bus,
    output logic                lcd_de,
    output logic                lcd_hs,
    output logic                lcd_vs,
    output logic                lcd_clk,
    output logic                lcd_bl,
    output logic [DW-1:0]       lcd_rgb
);
    localparam int unsigned TW = CW + 2;

    typedef struct packed {
        logic [CW-1:0] h_sync;
        logic [CW-1:0] h_back;
        logic [CW-1:0] h_disp;
        logic [CW-1:0] h_front;
        logic [CW-1:0] v_sync;
        logic [CW-1:0] v_back;
        logic [CW-1:0] v_disp;
        logic [CW-1:0] v_front;
    } timing_t;

    localparam timing_t RST_SET = '{
        h_sync:  CW'(RST_H_SYNC),  h_back: CW'(RST_H_BACK),
        h_disp:  CW'(RST_H_DISP),  h_front: CW'(RST_H_FRONT),
        v_sync:  CW'(RST_V_SYNC),  v_back: CW'(RST_V_BACK),
        v_disp:  CW'(RST_V_DISP),  v_front: CW'(RST_V_FRONT)
    };
    localparam logic [TW-1:0] TOT_LIMIT = TW'(1) << CW;

    timing_t       r_active;
    timing_t       r_pending;
    logic          r_pend;
    logic [CW-1:0] r_h_cnt;
    logic [CW-1:0] r_v_cnt;

    timing_t       w_offer;
    logic [TW-1:0] w_offer_hs;
    logic [TW-1:0] w_offer_h_tot;
    logic [TW-1:0] w_offer_v_tot;
    logic          w_bad;
    logic          w_xfer;
    logic [TW-1:0] w_h_total;
    logic [TW-1:0] w_v_total;
    logic [TW-1:0] w_hc;
    logic [TW-1:0] w_vc;
    logic          w_h_end;
    logic          w_v_end;
    logic          w_frame_end;
    logic [TW-1:0] w_hs;
    logic [TW-1:0] w_vs;
    logic [TW-1:0] w_req_lo;
    logic          w_vwin;
    logic          w_req;

    // Validation of the offered set happens combinationally in the transfer cycle.
    assign w_offer = '{
        h_sync: bus.cfg_h_sync, h_back: bus.cfg_h_back,
        h_disp: bus.cfg_h_disp, h_front: bus.cfg_h_front,
        v_sync: bus.cfg_v_sync, v_back: bus.cfg_v_back,
        v_disp: bus.cfg_v_disp, v_front: bus.cfg_v_front
    };
    assign w_offer_hs    = TW'(w_offer.h_sync) + TW'(w_offer.h_back);
    assign w_offer_h_tot = w_offer_hs + TW'(w_offer.h_disp) + TW'(w_offer.h_front);
    assign w_offer_v_tot = TW'(w_offer.v_sync) + TW'(w_offer.v_back)
                         + TW'(w_offer.v_disp) + TW'(w_offer.v_front);
    assign w_bad = (w_offer.h_sync == '0) || (w_offer.v_sync == '0)
                || (w_offer.h_disp == '0) || (w_offer.v_disp == '0)
                || (w_offer_hs < TW'(REQ_LEAD))
                || (w_offer_h_tot >= TOT_LIMIT) || (w_offer_v_tot >= TOT_LIMIT);
    assign w_xfer = bus.cfg_valid && !r_pend;

    assign bus.cfg_ready = !r_pend;
    assign bus.cfg_err   = w_xfer && w_bad;

    assign w_h_total = TW'(r_active.h_sync) + TW'(r_active.h_back)
                     + TW'(r_active.h_disp) + TW'(r_active.h_front);
    assign w_v_total = TW'(r_active.v_sync) + TW'(r_active.v_back)
                     + TW'(r_active.v_disp) + TW'(r_active.v_front);
    assign w_hc        = TW'(r_h_cnt);
    assign w_vc        = TW'(r_v_cnt);
    assign w_h_end     = (w_hc == w_h_total - TW'(1));
    assign w_v_end     = (w_vc == w_v_total - TW'(1));
    assign w_frame_end = w_h_end && w_v_end;

    // Counters plus pending/active timing sets; an apply and a new transfer never collide
    // because a transfer needs pend=0 and an apply needs pend=1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active  <= RST_SET;
            r_pending <= RST_SET;
            r_pend    <= 1'b0;
            r_h_cnt   <= '0;
            r_v_cnt   <= '0;
        end else begin
            r_h_cnt <= w_h_end ? '0 : r_h_cnt + CW'(1);
            if (w_h_end) begin
                r_v_cnt <= w_v_end ? '0 : r_v_cnt + CW'(1);
            end
            if (w_frame_end && r_pend) begin
                r_active <= r_pending;
                r_pend   <= 1'b0;
            end else if (w_xfer && !w_bad) begin
                r_pending <= w_offer;
                r_pend    <= 1'b1;
            end
        end
    end

    assign w_hs     = TW'(r_active.h_sync) + TW'(r_active.h_back);
    assign w_vs     = TW'(r_active.v_sync) + TW'(r_active.v_back);
    assign w_req_lo = w_hs - TW'(REQ_LEAD);
    assign w_vwin   = (w_vc >= w_vs) && (w_vc < w_vs + TW'(r_active.v_disp));
    assign w_req    = w_vwin && (w_hc >= w_req_lo)
                   && (w_hc < w_req_lo + TW'(r_active.h_disp));

    assign lcd_de = w_vwin && (w_hc >= w_hs) && (w_hc < w_hs + TW'(r_active.h_disp));

    assign bus.pixel_req   = w_req;
    assign bus.pixel_x     = w_req ? CW'(w_hc - w_req_lo) : '0;
    assign bus.pixel_y     = w_req ? CW'(w_vc - w_vs) : '0;
    assign bus.h_disp      = r_active.h_disp;
    assign bus.v_disp      = r_active.v_disp;
    assign bus.frame_start = (r_h_cnt == '0) && (r_v_cnt == '0);
    assign bus.line_start  = (r_h_cnt == '0);

    generate
        if (DE_MODE) begin : g_de_only
            assign lcd_hs = 1'b1;
            assign lcd_vs = 1'b1;
        end else begin : g_hv_sync
            assign lcd_hs = (r_h_cnt < r_active.h_sync) ? HS_POL : ~HS_POL;
            assign lcd_vs = (r_v_cnt < r_active.v_sync) ? VS_POL : ~VS_POL;
        end
    endgenerate

    assign lcd_clk = clk;
    assign lcd_bl  = 1'b1;
    assign lcd_rgb = lcd_de ? bus.pixel_data : '0;
endmodule

// File: tb/tb_lcd_timing_engine.sv
// Bench for lcd_timing_engine: default 480x272 instance plus a small-frame
// instance exercising config handshake, sync decode and the pixel source path.
`timescale 1ns/1ps
module tb_lcd_timing_engine;
    localparam int unsigned CW     = 11;
    localparam int unsigned DW     = 24;
    localparam int unsigned LEAD_B = 3;
    localparam int unsigned NV     = 9;

    typedef struct {
        logic [CW-1:0] hs, hb, hd, hf, vs, vb, vd, vf;
        logic          err;
    } cfg_vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    lcd_timing_engine_if #(.CW(CW), .DW(DW)) ifa ();
    lcd_timing_engine_if #(.CW(CW), .DW(DW)) ifb ();

    logic          a_de, a_hs, a_vs, a_lclk, a_bl;
    logic [DW-1:0] a_rgb;
    logic          b_de, b_hs, b_vs, b_lclk, b_bl;
    logic [DW-1:0] b_rgb;

    lcd_timing_engine #(
        .CW(CW), .DW(DW), .REQ_LEAD(1), .DE_MODE(1'b1), .HS_POL(1'b0), .VS_POL(1'b0)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa),
        .lcd_de(a_de), .lcd_hs(a_hs), .lcd_vs(a_vs), .lcd_clk(a_lclk), .lcd_bl(a_bl),
        .lcd_rgb(a_rgb)
    );

    lcd_timing_engine #(
        .CW(CW), .DW(DW), .REQ_LEAD(LEAD_B), .DE_MODE(1'b0), .HS_POL(1'b0), .VS_POL(1'b1),
        .RST_H_SYNC(4), .RST_H_BACK(3), .RST_H_DISP(8), .RST_H_FRONT(2),
        .RST_V_SYNC(2), .RST_V_BACK(1), .RST_V_DISP(5), .RST_V_FRONT(2)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb),
        .lcd_de(b_de), .lcd_hs(b_hs), .lcd_vs(b_vs), .lcd_clk(b_lclk), .lcd_bl(b_bl),
        .lcd_rgb(b_rgb)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    function automatic cfg_vec_t mk(input int hs, input int hb, input int hd, input int hf,
                                    input int vs, input int vb, input int vd, input int vf,
                                    input bit err);
        cfg_vec_t v;
        v.hs = CW'(hs); v.hb = CW'(hb); v.hd = CW'(hd); v.hf = CW'(hf);
        v.vs = CW'(vs); v.vb = CW'(vb); v.vd = CW'(vd); v.vf = CW'(vf);
        v.err = err;
        return v;
    endfunction

    // Pixel source for instance B: returns {x,y} of each request LEAD_B cycles later.
    logic [DW-1:0] src_pipe [LEAD_B];
    always @(posedge clk) begin
        src_pipe[0] <= ifb.pixel_req ? DW'({ifb.pixel_x, ifb.pixel_y}) : '0;
        for (int i = 1; i < LEAD_B; i++) src_pipe[i] <= src_pipe[i-1];
    end
    assign ifb.pixel_data = src_pipe[LEAD_B-1];

    // Scoreboard: expected coordinate from request run ordering, compared on DE.
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] sb_exp;
    int  run_x, run_y;
    bit  prev_req;
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            run_x    = 0;
            run_y    = 0;
            prev_req = 1'b0;
        end else begin
            if (ifb.frame_start) run_y = 0;
            if (ifb.pixel_req) begin
                run_x = prev_req ? run_x + 1 : 0;
                exp_q.push_back(DW'({CW'(run_x), CW'(run_y)}));
            end else begin
                if (prev_req) run_y++;
                check("xy_idle", 32'({ifb.pixel_x, ifb.pixel_y}), 32'(0));
            end
            prev_req = ifb.pixel_req;
            if (b_de) begin
                check("sb_level", 32'(exp_q.size() != 0), 32'(1));
                if (exp_q.size() != 0) begin
                    sb_exp = exp_q.pop_front();
                    check("lcd_rgb", 32'(b_rgb), 32'(sb_exp));
                end
            end
        end
    end

    task automatic wait_frame_start();
        bit ok = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (ifb.frame_start) begin
                ok = 1'b1;
                break;
            end
        end
        check("frame_start_seen", 32'(ok), 32'(1));
    endtask

    // Called on the negedge of a frame_start cycle; returns on the next one.
    task automatic measure_frame(input cfg_vec_t v);
        int cyc = 0, de = 0, req = 0, hsn = 0, vsn = 0, ls = 0, first_de = -1, max_y = 0;
        bit done = 1'b0;
        int ht = int'(v.hs) + int'(v.hb) + int'(v.hd) + int'(v.hf);
        int vt = int'(v.vs) + int'(v.vb) + int'(v.vd) + int'(v.vf);
        for (int k = 0; k < 20000; k++) begin
            if (k > 0 && ifb.frame_start) begin
                done = 1'b1;
                break;
            end
            cyc++;
            if (b_de) begin
                de++;
                if (first_de < 0) first_de = k;
            end
            if (ifb.pixel_req) begin
                req++;
                if (int'(ifb.pixel_y) > max_y) max_y = int'(ifb.pixel_y);
            end
            if (b_hs == 1'b0) hsn++;
            if (b_vs == 1'b1) vsn++;
            if (ifb.line_start) ls++;
            @(negedge clk);
        end
        check("frame_done", 32'(done), 32'(1));
        check("frame_period", 32'(cyc), 32'(ht * vt));
        check("de_count", 32'(de), 32'(int'(v.hd) * int'(v.vd)));
        check("req_count", 32'(req), 32'(int'(v.hd) * int'(v.vd)));
        check("hs_active", 32'(hsn), 32'(int'(v.hs) * vt));
        check("vs_active", 32'(vsn), 32'(int'(v.vs) * ht));
        check("line_starts", 32'(ls), 32'(vt));
        check("first_de", 32'(first_de),
              32'((int'(v.vs) + int'(v.vb)) * ht + int'(v.hs) + int'(v.hb)));
        check("max_pixel_y", 32'(max_y), 32'(int'(v.vd) - 1));
    endtask

    task automatic drive_cfg(input cfg_vec_t v);
        ifb.cfg_valid   = 1'b1;
        ifb.cfg_h_sync  = v.hs; ifb.cfg_h_back = v.hb;
        ifb.cfg_h_disp  = v.hd; ifb.cfg_h_front = v.hf;
        ifb.cfg_v_sync  = v.vs; ifb.cfg_v_back = v.vb;
        ifb.cfg_v_disp  = v.vd; ifb.cfg_v_front = v.vf;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cfg_vec_t vec [NV];
        cfg_vec_t cur, sx, sy, sz;
        int a_de_cnt;

        vec[0] = mk(3, 2, 10, 1,   1, 2, 6, 1,    1'b0);
        vec[1] = mk(3, 2, 0, 1,    1, 2, 6, 1,    1'b1);  // h_disp = 0
        vec[2] = mk(1, 1, 10, 1,   1, 2, 6, 1,    1'b1);  // HS = 2 < lead 3
        vec[3] = mk(2, 1, 6, 1,    1, 1, 4, 1,    1'b0);  // HS == lead
        vec[4] = mk(3, 2, 10, 1,   0, 2, 6, 1,    1'b1);  // v_sync = 0
        vec[5] = mk(1000, 500, 500, 48, 1, 1, 1, 1, 1'b1); // h_total = 2048
        vec[6] = mk(1000, 500, 500, 47, 1, 1, 1, 1, 1'b0); // h_total = 2047
        vec[7] = mk(4, 3, 8, 2,    1, 1, 2046, 0, 1'b1);  // v_total = 2048
        vec[8] = mk(5, 2, 12, 3,   3, 2, 7, 2,    1'b0);
        cur = mk(4, 3, 8, 2, 2, 1, 5, 2, 1'b0);
        sx  = mk(4, 2, 9, 2,  2, 2, 6, 2, 1'b0);
        sy  = mk(3, 3, 7, 1,  1, 1, 5, 1, 1'b0);
        sz  = mk(2, 2, 11, 3, 2, 1, 4, 2, 1'b0);

        rst_n = 1'b0;
        ifa.cfg_valid = 1'b0; ifa.pixel_data = 24'hA5A5A5;
        ifa.cfg_h_sync = '0; ifa.cfg_h_back = '0; ifa.cfg_h_disp = '0; ifa.cfg_h_front = '0;
        ifa.cfg_v_sync = '0; ifa.cfg_v_back = '0; ifa.cfg_v_disp = '0; ifa.cfg_v_front = '0;
        drive_cfg(cur);
        ifb.cfg_valid = 1'b0;
        repeat (3) @(negedge clk);

        // Output values while in reset.
        check("rst_a_de", 32'(a_de), 32'(0));
        check("rst_a_req", 32'(ifa.pixel_req), 32'(0));
        check("rst_a_xy", 32'({ifa.pixel_x, ifa.pixel_y}), 32'(0));
        check("rst_a_frame_start", 32'(ifa.frame_start), 32'(1));
        check("rst_a_line_start", 32'(ifa.line_start), 32'(1));
        check("rst_a_cfg_ready", 32'(ifa.cfg_ready), 32'(1));
        check("rst_a_cfg_err", 32'(ifa.cfg_err), 32'(0));
        check("rst_a_h_disp", 32'(ifa.h_disp), 32'(480));
        check("rst_a_v_disp", 32'(ifa.v_disp), 32'(272));
        check("rst_a_hs_vs", 32'({a_hs, a_vs}), 32'(3));
        check("rst_a_rgb", 32'(a_rgb), 32'(0));
        check("rst_a_bl", 32'(a_bl), 32'(1));
        check("rst_b_hs", 32'(b_hs), 32'(0));
        check("rst_b_vs", 32'(b_vs), 32'(1));
        check("rst_b_h_disp", 32'(ifb.h_disp), 32'(8));

        rst_n = 1'b1;
        a_de_cnt = 0;
        // Default 480x272 timing: first active line is v=12, HS = 43.
        for (int k = 0; k <= 6823; k++) begin
            #1;
            if (a_de) a_de_cnt++;
            case (k)
                0:    check("a_frame_start_k0", 32'(ifa.frame_start), 32'(1));
                1:    check("a_frame_start_k1", 32'(ifa.frame_start), 32'(0));
                525:  check("a_line_start_l1", 32'(ifa.line_start), 32'(1));
                6341: check("a_req_before", 32'(ifa.pixel_req), 32'(0));
                6342: begin
                    check("a_req_first", 32'(ifa.pixel_req), 32'(1));
                    check("a_x_first", 32'(ifa.pixel_x), 32'(0));
                    check("a_y_first", 32'(ifa.pixel_y), 32'(0));
                    check("a_de_before", 32'(a_de), 32'(0));
                end
                6343: begin
                    check("a_de_first", 32'(a_de), 32'(1));
                    check("a_rgb_first", 32'(a_rgb), 32'(24'hA5A5A5));
                    check("a_hs_vs_active", 32'({a_hs, a_vs}), 32'(3));
                end
                6821: begin
                    check("a_req_last", 32'(ifa.pixel_req), 32'(1));
                    check("a_x_last", 32'(ifa.pixel_x), 32'(479));
                end
                6822: begin
                    check("a_req_after", 32'(ifa.pixel_req), 32'(0));
                    check("a_de_last", 32'(a_de), 32'(1));
                end
                6823: check("a_de_after", 32'(a_de), 32'(0));
                default: ;
            endcase
            @(negedge clk);
        end
        check("a_de_count_line", 32'(a_de_cnt), 32'(480));

        // Instance B reset-set frame.
        wait_frame_start();
        check("b_h_disp_rst", 32'(ifb.h_disp), 32'(cur.hd));
        measure_frame(cur);

        for (int i = 0; i < NV; i++) begin
            wait_frame_start();
            drive_cfg(vec[i]);
            #1;
            check("cfg_ready_pre", 32'(ifb.cfg_ready), 32'(1));
            check("cfg_err", 32'(ifb.cfg_err), 32'(vec[i].err));
            @(negedge clk);
            ifb.cfg_valid = 1'b0;
            #1;
            check("cfg_err_clear", 32'(ifb.cfg_err), 32'(0));
            check("cfg_ready_post", 32'(ifb.cfg_ready), 32'(vec[i].err ? 1 : 0));
            if (!vec[i].err) begin
                check("h_disp_old", 32'(ifb.h_disp), 32'(cur.hd));
                wait_frame_start();
                check("cfg_ready_applied", 32'(ifb.cfg_ready), 32'(1));
                check("h_disp_new", 32'(ifb.h_disp), 32'(vec[i].hd));
                check("v_disp_new", 32'(ifb.v_disp), 32'(vec[i].vd));
                measure_frame(vec[i]);
                cur = vec[i];
            end else begin
                check("h_disp_kept", 32'(ifb.h_disp), 32'(cur.hd));
                check("v_disp_kept", 32'(ifb.v_disp), 32'(cur.vd));
            end
        end

        // Second offer while a set is pending: blocked, then taken at the boundary.
        wait_frame_start();
        drive_cfg(sx);
        @(negedge clk);
        drive_cfg(sy);
        for (int j = 0; j < 4; j++) begin
            #1;
            check("busy_ready", 32'(ifb.cfg_ready), 32'(0));
            check("busy_err", 32'(ifb.cfg_err), 32'(0));
            @(negedge clk);
        end
        wait_frame_start();
        check("x_applied", 32'(ifb.h_disp), 32'(sx.hd));
        check("y_ready_at_boundary", 32'(ifb.cfg_ready), 32'(1));
        @(negedge clk);
        ifb.cfg_valid = 1'b0;
        #1;
        check("y_pending", 32'(ifb.cfg_ready), 32'(0));
        check("x_still_active", 32'(ifb.h_disp), 32'(sx.hd));
        wait_frame_start();
        check("y_applied_h", 32'(ifb.h_disp), 32'(sy.hd));
        check("y_applied_v", 32'(ifb.v_disp), 32'(sy.vd));
        measure_frame(sy);

        // Transfer in the frame-end cycle lands one frame later.
        repeat (14 * 8 - 1) @(negedge clk);
        drive_cfg(sz);
        #1;
        check("z_ready_at_end", 32'(ifb.cfg_ready), 32'(1));
        check("z_err", 32'(ifb.cfg_err), 32'(0));
        @(negedge clk);
        ifb.cfg_valid = 1'b0;
        #1;
        check("z_frame_start", 32'(ifb.frame_start), 32'(1));
        check("z_not_yet", 32'(ifb.h_disp), 32'(sy.hd));
        check("z_pending", 32'(ifb.cfg_ready), 32'(0));
        wait_frame_start();
        check("z_applied", 32'(ifb.h_disp), 32'(sz.hd));
        check("z_ready_after", 32'(ifb.cfg_ready), 32'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
